lsu_subword_ctrl: RTL and testbench

//  Load/store controller directly upstream of the word-only data memory.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_subword_ctrl_if.sv | 39 +++
 rtl/byte_lane_unit.sv | 44 ++++
 rtl/lsu_subword_ctrl.sv | 139 +++++++++++++
 tb/tb_lsu_subword_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the sub-word load/store controller.
//   width_e : request access width encoding (matches req_width bits)
//   state_e : controller FSM states
//   is_aligned / align_lo : alignment test and low-address alignment helpers
package lsu_pkg;

    typedef enum logic [1:0] {
        W_WORD = 2'b00,
        W_HALF = 2'b01,
        W_BYTE = 2'b10,
        W_RSVD = 2'b11
    } width_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_MERGE = 1'b1
    } state_e;

    function automatic logic is_aligned(input logic [1:0] addr_lo, input width_e width);
        case (width)
            W_WORD:  return (addr_lo == 2'b00);
            W_HALF:  return !addr_lo[0];
            default: return 1'b1;
        endcase
    endfunction

    // Low address bits rounded down to the natural alignment of the access.
    function automatic logic [1:0] align_lo(input logic [1:0] addr_lo, input width_e width);
        case (width)
            W_WORD:  return 2'b00;
            W_HALF:  return {addr_lo[1], 1'b0};
            default: return addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_subword_ctrl_if.sv
// Bus bundle between requester, controller and word-only data memory.
//   req_* / resp_* : CPU request/response handshake
//   dm_*           : data-memory word port (dm_rdata is combinational read data)
// Modports:
//   master : requester + memory side (drives requests and dm_rdata)
//   slave  : controller side
interface lsu_subword_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_width;
    logic              req_sign;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [DATA_W-1:0] resp_rdata;
    logic              dm_we;
    logic [1:0]        dm_width;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;

    modport master (
        output req_valid, req_we, req_width, req_sign, req_addr, req_wdata, dm_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  dm_we, dm_width, dm_addr, dm_wdata
    );

    modport slave (
        input  req_valid, req_we, req_width, req_sign, req_addr, req_wdata, dm_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output dm_we, dm_width, dm_addr, dm_wdata
    );

endinterface

// File: rtl/byte_lane_unit.sv
// Combinational little-endian lane logic for a 32-bit word.
//   ld_* : extract the addressed half/byte from ld_word, zero- or sign-extend -> ld_data
//   st_* : replace the addressed lane of st_old with the low bits of st_wdata -> st_word
// Word accesses pass data through unchanged; ld_sign is ignored for words.
module byte_lane_unit
    import lsu_pkg::*;
(
    input  logic [31:0] ld_word,
    input  logic [1:0]  ld_lo,
    input  width_e      ld_width,
    input  logic        ld_sign,
    output logic [31:0] ld_data,
    input  logic [31:0] st_old,
    input  logic [31:0] st_wdata,
    input  logic [1:0]  st_lo,
    input  width_e      st_width,
    output logic [31:0] st_word
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = ld_lo[1] ? ld_word[31:16] : ld_word[15:0];
        byte_sel = ld_word[{ld_lo, 3'b000} +: 8];
        ld_data  = ld_word;
        case (ld_width)
            W_HALF:  ld_data = {{16{ld_sign & half_sel[15]}}, half_sel};
            W_BYTE:  ld_data = {{24{ld_sign & byte_sel[7]}}, byte_sel};
            default: ld_data = ld_word;
        endcase
    end

    always_comb begin
        st_word = st_old;
        case (st_width)
            W_WORD:  st_word = st_wdata;
            W_HALF:  st_word[{st_lo[1], 4'b0000} +: 16] = st_wdata[15:0];
            W_BYTE:  st_word[{st_lo, 3'b000} +: 8] = st_wdata[7:0];
            default: st_word = st_old;
        endcase
    end

endmodule

// File: rtl/lsu_subword_ctrl.sv
// Load/store controller in front of a word-only data memory.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : lsu_subword_ctrl_if.slave (request/response handshake + DM word port)
// Loads and word stores complete in one cycle; half/byte stores sample the old
// word, then write the merged word one cycle later (read-modify-write).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready; loads, word stores and errors handled in this cycle
// S_MERGE | writing merged word for a pending half/byte store
module lsu_subword_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MISALIGN_TRAP = 1
) (
    input  logic              clk,
    input  logic              reset,
    lsu_subword_ctrl_if.slave bus
);

    state_e            state;
    logic [ADDR_W-1:0] addr_q;
    width_e            width_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] old_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [DATA_W-1:0] resp_rdata_q;

    width_e            req_w;
    logic              req_acc;
    logic              req_err;
    logic              req_sub;
    logic [ADDR_W-1:0] eff_addr;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] merge_data;

    assign req_w   = width_e'(bus.req_width);
    assign req_acc = bus.req_valid && (state == S_IDLE);
    assign req_sub = (req_w == W_HALF) || (req_w == W_BYTE);
    assign req_err = (req_w == W_RSVD) ||
                     ((MISALIGN_TRAP != 0) && !is_aligned(bus.req_addr[1:0], req_w));

    // With trapping enabled only aligned requests get here, so clearing the
    // low bits is a no-op; without trapping it implements the round-down.
    always_comb begin
        eff_addr      = bus.req_addr;
        eff_addr[1:0] = align_lo(bus.req_addr[1:0], req_w);
    end

    byte_lane_unit u_lanes (
        .ld_word  (bus.dm_rdata),
        .ld_lo    (eff_addr[1:0]),
        .ld_width (req_w),
        .ld_sign  (bus.req_sign),
        .ld_data  (ld_data),
        .st_old   (old_q),
        .st_wdata (wdata_q),
        .st_lo    (addr_q[1:0]),
        .st_width (width_q),
        .st_word  (merge_data)
    );

    assign bus.req_ready  = (state == S_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.dm_width   = W_WORD;

    // DM port is combinational from the accepted request (IDLE) or the held
    // store (MERGE). Gating with reset keeps a write from slipping out while
    // reset is held, even if the requester keeps req_valid high.
    always_comb begin
        bus.dm_we    = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
        if (reset) begin
            if (state == S_MERGE) begin
                bus.dm_we    = 1'b1;
                bus.dm_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                bus.dm_wdata = merge_data;
            end else if (req_acc && !req_err) begin
                bus.dm_addr = {eff_addr[ADDR_W-1:2], 2'b00};
                if (bus.req_we && (req_w == W_WORD)) begin
                    bus.dm_we    = 1'b1;
                    bus.dm_wdata = bus.req_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            addr_q       <= '0;
            width_q      <= W_WORD;
            wdata_q      <= '0;
            old_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            case (state)
                S_IDLE: begin
                    if (req_acc) begin
                        if (req_err) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (!bus.req_we) begin
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= ld_data;
                        end else if (req_sub) begin
                            addr_q  <= eff_addr;
                            width_q <= req_w;
                            wdata_q <= bus.req_wdata;
                            old_q   <= bus.dm_rdata;
                            state   <= S_MERGE;
                        end else begin
                            resp_valid_q <= 1'b1;
                        end
                    end
                end
                S_MERGE: begin
                    state        <= S_IDLE;
                    resp_valid_q <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_subword_ctrl.sv
// Self-checking bench for lsu_subword_ctrl: directed scenarios plus a random
// request stream, checked against a byte-addressed reference memory model.
module tb_lsu_subword_ctrl;

    typedef struct {
        logic        we;
        logic [1:0]  w;
        logic        s;
        logic [31:0] a;
        logic [31:0] wd;
    } req_t;

    logic clk;
    logic reset;
    logic mem_clear;

    lsu_subword_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    lsu_subword_ctrl #(.ADDR_W(32), .DATA_W(32), .MISALIGN_TRAP(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment data memory (word-only, combinational read)
    logic [31:0] env_mem [0:1023];
    int          wr_count;
    logic [31:0] last_wr_data;

    assign bus.dm_rdata = env_mem[bus.dm_addr[11:2]];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) env_mem[i] <= '0;
            wr_count     <= 0;
            last_wr_data <= '0;
        end else if (bus.dm_we) begin
            env_mem[bus.dm_addr[11:2]] <= bus.dm_wdata;
            wr_count                   <= wr_count + 1;
            last_wr_data               <= bus.dm_wdata;
        end
    end

    // Reference model: byte-addressed memory
    logic [7:0] ref_mem [0:4095];
    int passed;
    int total;
    req_t stream_q[$];

    function automatic int nbytes(input logic [1:0] w);
        if (w == 2'd0) return 4;
        if (w == 2'd1) return 2;
        return 1;
    endfunction

    function automatic logic ref_is_err(input logic [1:0] w, input logic [31:0] a);
        if (w == 2'd3) return 1'b1;
        return (a % nbytes(w)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] w, input logic s, input logic [31:0] a);
        logic [31:0] v;
        int n;
        n = nbytes(w);
        v = 0;
        for (int i = 0; i < n; i++) v = v + (32'(ref_mem[(a + i) % 4096]) << (8 * i));
        if (s && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] w, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < nbytes(w); i++) ref_mem[(a + i) % 4096] = 8'((wd >> (8 * i)) & 32'hFF);
    endtask

    // Single request; reports latency (cycles accept->resp_valid), response,
    // DM write count, last written word and req_ready one cycle after accept.
    task automatic do_req(input logic we, input logic [1:0] w, input logic s,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic err, output logic [31:0] rd,
                          output int writes, output logic [31:0] wr_data, output logic rdy_after);
        int n;
        int w0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_width = w;
        bus.req_sign  = s;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        w0 = wr_count;
        @(negedge clk);
        bus.req_valid = 1'b0;
        rdy_after = bus.req_ready;
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        err     = bus.resp_err;
        rd      = bus.resp_rdata;
        writes  = wr_count - w0;
        wr_data = last_wr_data;
    endtask

    task automatic test_reset();
        total++; if (bus.req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus.req_ready); else passed++;
        total++; if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0) $display("FAIL reset_resp: got %b%b expected 00", bus.resp_valid, bus.resp_err); else passed++;
        total++; if (bus.resp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", bus.resp_rdata); else passed++;
        total++; if ({bus.dm_we, bus.dm_width, bus.dm_addr, bus.dm_wdata} !== 67'h0)
            $display("FAIL reset_dm: got we=%b width=%b addr=%h wdata=%h expected all 0", bus.dm_we, bus.dm_width, bus.dm_addr, bus.dm_wdata);
        else passed++;
    endtask

    task automatic test_word();
        int lat, wr; logic err, rdy; logic [31:0] rd, wdat, exp;
        do_req(1'b1, 2'd0, 1'b0, 32'h10, 32'h1234_5678, lat, err, rd, wr, wdat, rdy);
        ref_store(2'd0, 32'h10, 32'h1234_5678);
        total++; if (lat !== 1 || err !== 1'b0) $display("FAIL word_store_resp: got lat=%0d err=%b expected lat=1 err=0", lat, err); else passed++;
        total++; if (wr !== 1 || wdat !== 32'h1234_5678) $display("FAIL word_store_write: got n=%0d data=%h expected n=1 data=12345678", wr, wdat); else passed++;
        do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, lat, err, rd, wr, wdat, rdy);
        exp = ref_load(2'd0, 1'b0, 32'h10);
        total++; if (lat !== 1 || rd !== exp) $display("FAIL word_load: got lat=%0d data=%h expected lat=1 data=%h", lat, rd, exp); else passed++;
        total++; if (wr !== 0) $display("FAIL word_load_nowrite: got %0d writes expected 0", wr); else passed++;
    endtask

    task automatic test_byte_merge();
        int lat, wr; logic err, rdy; logic [31:0] rd, wdat, exp;
        do_req(1'b1, 2'd2, 1'b0, 32'h11, 32'h0000_00AB, lat, err, rd, wr, wdat, rdy);
        ref_store(2'd2, 32'h11, 32'h0000_00AB);
        exp = ref_load(2'd0, 1'b0, 32'h10);
        total++; if (lat !== 2 || rdy !== 1'b0) $display("FAIL byte_store_timing: got lat=%0d ready=%b expected lat=2 ready=0", lat, rdy); else passed++;
        total++; if (wr !== 1 || wdat !== exp) $display("FAIL byte_store_merge: got n=%0d data=%h expected n=1 data=%h", wr, wdat, exp); else passed++;
        total++; if (err !== 1'b0 || rd !== 32'h0) $display("FAIL byte_store_resp: got err=%b data=%h expected 0 0", err, rd); else passed++;
    endtask

    task automatic test_signed_loads();
        int lat, wr; logic err, rdy; logic [31:0] rd, wdat, exp;
        logic [1:0]  lw [3];
        logic        ls [3];
        logic [31:0] la [3];
        lw = '{2'd2, 2'd2, 2'd1};
        ls = '{1'b1, 1'b1, 1'b0};
        la = '{32'h20, 32'h21, 32'h22};
        do_req(1'b1, 2'd0, 1'b0, 32'h20, 32'h8000_FF7F, lat, err, rd, wr, wdat, rdy);
        ref_store(2'd0, 32'h20, 32'h8000_FF7F);
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, lw[i], ls[i], la[i], 32'h0, lat, err, rd, wr, wdat, rdy);
            exp = ref_load(lw[i], ls[i], la[i]);
            total++; if (lat !== 1 || err !== 1'b0 || rd !== exp)
                $display("FAIL ext_load_%0d: got lat=%0d err=%b data=%h expected lat=1 err=0 data=%h", i, lat, err, rd, exp);
            else passed++;
        end
    endtask

    task automatic test_errors();
        int lat, wr; logic err, rdy; logic [31:0] rd, wdat;
        logic        ew [4];
        logic [1:0]  ewd [4];
        logic [31:0] ea [4];
        ew  = '{1'b0, 1'b1, 1'b0, 1'b1};
        ewd = '{2'd1, 2'd0, 2'd3, 2'd3};
        ea  = '{32'h21, 32'h22, 32'h24, 32'h24};
        for (int i = 0; i < 4; i++) begin
            do_req(ew[i], ewd[i], 1'b1, ea[i], 32'hDEAD_BEEF, lat, err, rd, wr, wdat, rdy);
            total++; if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || wr !== 0)
                $display("FAIL error_%0d: got lat=%0d err=%b data=%h writes=%0d expected lat=1 err=1 data=0 writes=0", i, lat, err, rd, wr);
            else passed++;
        end
    endtask

    task automatic test_reset_in_merge();
        int w0, lat, wr; logic err, rdy; logic [31:0] rd, wdat, exp;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_width = 2'd1; bus.req_sign = 1'b0;
        bus.req_addr = 32'h12; bus.req_wdata = 32'h0000_BEEF;
        w0 = wr_count;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        total++; if (bus.req_ready !== 1'b0) $display("FAIL merge_entered: got ready=%b expected 0", bus.req_ready); else passed++;
        #2 reset = 1'b0;
        #1;
        total++; if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.dm_we} !== 4'b1000 || bus.dm_addr !== 32'h0 || bus.dm_wdata !== 32'h0 || bus.resp_rdata !== 32'h0)
            $display("FAIL reset_in_merge_outputs: got ready=%b rv=%b re=%b we=%b addr=%h wdata=%h rd=%h expected ready=1 rest 0",
                     bus.req_ready, bus.resp_valid, bus.resp_err, bus.dm_we, bus.dm_addr, bus.dm_wdata, bus.resp_rdata);
        else passed++;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        total++; if (wr_count !== w0) $display("FAIL reset_in_merge_nowrite: got %0d writes expected 0", wr_count - w0); else passed++;
        do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, lat, err, rd, wr, wdat, rdy);
        exp = ref_load(2'd0, 1'b0, 32'h10);
        total++; if (lat !== 1 || err !== 1'b0 || rd !== exp)
            $display("FAIL after_reset_load: got lat=%0d err=%b data=%h expected lat=1 err=0 data=%h", lat, err, rd, exp);
        else passed++;
    endtask

    // Drives stream_q with req_valid held continuously; each response is
    // compared against the model evaluated in acceptance order.
    task automatic run_stream(input string tag);
        logic [32:0] exp_q[$];
        logic [32:0] exp;
        int n, idx, got, cyc, exp_writes, w0;
        logic acc;
        n = stream_q.size();
        idx = 0; got = 0; cyc = 0; exp_writes = 0;
        w0 = wr_count;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_we = stream_q[0].we; bus.req_width = stream_q[0].w; bus.req_sign = stream_q[0].s;
        bus.req_addr = stream_q[0].a; bus.req_wdata = stream_q[0].wd;
        while (got < n && cyc < n * 4 + 20) begin
            @(negedge clk);
            cyc++;
            if (bus.resp_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL %s_spurious_resp: got resp_valid expected none", tag);
                end else begin
                    exp = exp_q.pop_front();
                    if ({bus.resp_err, bus.resp_rdata} !== exp)
                        $display("FAIL %s_resp_%0d: got err=%b data=%h expected err=%b data=%h", tag, got, bus.resp_err, bus.resp_rdata, exp[32], exp[31:0]);
                    else passed++;
                end
                got++;
            end
            acc = bus.req_valid && bus.req_ready;
            if (acc) begin
                if (ref_is_err(stream_q[idx].w, stream_q[idx].a)) begin
                    exp_q.push_back({1'b1, 32'h0});
                end else if (stream_q[idx].we) begin
                    ref_store(stream_q[idx].w, stream_q[idx].a, stream_q[idx].wd);
                    exp_q.push_back({1'b0, 32'h0});
                    exp_writes++;
                end else begin
                    exp_q.push_back({1'b0, ref_load(stream_q[idx].w, stream_q[idx].s, stream_q[idx].a)});
                end
                idx++;
            end
            @(posedge clk); #1;
            if (acc) begin
                if (idx < n) begin
                    bus.req_we = stream_q[idx].we; bus.req_width = stream_q[idx].w; bus.req_sign = stream_q[idx].s;
                    bus.req_addr = stream_q[idx].a; bus.req_wdata = stream_q[idx].wd;
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
        end
        bus.req_valid = 1'b0;
        total++; if (got !== n || idx !== n) $display("FAIL %s_count: got %0d resp %0d accepted expected %0d", tag, got, idx, n); else passed++;
        total++; if (wr_count - w0 !== exp_writes) $display("FAIL %s_writes: got %0d expected %0d", tag, wr_count - w0, exp_writes); else passed++;
        stream_q.delete();
    endtask

    task automatic test_back_to_back();
        stream_q.push_back('{we: 1'b0, w: 2'd0, s: 1'b0, a: 32'h30, wd: 32'h0});
        stream_q.push_back('{we: 1'b1, w: 2'd2, s: 1'b0, a: 32'h31, wd: 32'h0000_005A});
        stream_q.push_back('{we: 1'b0, w: 2'd0, s: 1'b0, a: 32'h30, wd: 32'h0});
        stream_q.push_back('{we: 1'b1, w: 2'd1, s: 1'b0, a: 32'h32, wd: 32'h0000_C3D4});
        stream_q.push_back('{we: 1'b0, w: 2'd1, s: 1'b1, a: 32'h32, wd: 32'h0});
        run_stream("b2b");
    endtask

    task automatic test_random();
        req_t r;
        for (int i = 0; i < 60; i++) begin
            r.we = 1'($urandom_range(0, 1));
            r.w  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r.s  = 1'($urandom_range(0, 1));
            r.a  = 32'h40 + 32'($urandom_range(0, 15));
            r.wd = $urandom();
            stream_q.push_back(r);
        end
        run_stream("rand");
    endtask

    initial begin
        passed = 0;
        total  = 0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        reset = 1'b0;
        mem_clear = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_width = 2'd0; bus.req_sign = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        mem_clear = 1'b0;
        test_reset();
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_word();
        test_byte_merge();
        test_signed_loads();
        test_errors();
        test_reset_in_merge();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
